// File: rtl/pzvip_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pzvip_stream_arbiter
// Purpose  : Packet-aware N-to-1 round-robin stream arbiter with a registered
//            two-entry skid buffer on the output side.
// Options  : PZVIP_STREAM_ARBITER_CHANNEL_ID_EN adds o_channel (source index).
// Revision : 1.0 - initial release
// ============================================================================
module pzvip_stream_arbiter #(
    parameter  int CHANNELS   = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int BE_WIDTH   = DATA_WIDTH / 8,
    localparam int ID_WIDTH   = $clog2(CHANNELS)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [CHANNELS-1:0]            i_valid,
    output logic [CHANNELS-1:0]            o_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
    input  logic [CHANNELS*BE_WIDTH-1:0]   i_byte_enable,
    input  logic [CHANNELS-1:0]            i_last,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic [BE_WIDTH-1:0]            o_byte_enable,
    output logic                           o_last
`ifdef PZVIP_STREAM_ARBITER_CHANNEL_ID_EN
    ,
    output logic [ID_WIDTH-1:0]            o_channel
`endif
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    localparam logic [ID_WIDTH:0]   c_NUM_CH  = (ID_WIDTH + 1)'(CHANNELS);
    localparam logic [ID_WIDTH-1:0] c_LAST_CH = ID_WIDTH'(CHANNELS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [ID_WIDTH-1:0]   w_grant_nxt;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [ID_WIDTH-1:0]   w_ptr_nxt;

    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_winner;
    logic [ID_WIDTH:0]     w_idx;
    logic [ID_WIDTH-1:0]   w_sel;
    logic                  w_can_accept;
    logic                  w_in_ack;
    logic [DATA_WIDTH-1:0] w_in_data;
    logic [BE_WIDTH-1:0]   w_in_be;
    logic                  w_in_last;

    logic                  r_not_full;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [BE_WIDTH-1:0]   r_out_be;
    logic                  r_out_last;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [BE_WIDTH-1:0]   r_skid_be;
    logic                  r_skid_last;
    logic                  w_out_free;
    logic                  w_skid_nxt;

    // Round-robin search starting at r_ptr; index wraps without a modulo so
    // non-power-of-2 channel counts never produce an out-of-range pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_idx = {1'b0, r_ptr} + (ID_WIDTH + 1)'(i);
            if (w_idx >= c_NUM_CH) begin
                w_idx = w_idx - c_NUM_CH;
            end
            if (!w_found && i_valid[w_idx[ID_WIDTH-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[ID_WIDTH-1:0];
            end
        end
    end

    assign w_sel        = (r_state == S_LOCKED) ? r_grant : w_winner;
    assign w_can_accept = r_not_full & ((r_state == S_LOCKED) | w_found);

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ready
            assign o_ready[c] = w_can_accept & (w_sel == ID_WIDTH'(c));
        end
    endgenerate

    assign w_in_ack  = |(i_valid & o_ready);
    assign w_in_data = i_data[int'(w_sel) * DATA_WIDTH +: DATA_WIDTH];
    assign w_in_be   = i_byte_enable[int'(w_sel) * BE_WIDTH +: BE_WIDTH];
    assign w_in_last = i_last[w_sel];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Single-beat packets are accepted from IDLE without taking the lock.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_in_ack) begin
                    w_ptr_nxt = (w_winner == c_LAST_CH) ? '0 : w_winner + 1'b1;
                    if (!w_in_last) begin
                        w_state_nxt = S_LOCKED;
                        w_grant_nxt = w_winner;
                    end
                end
            end
            S_LOCKED: begin
                if (w_in_ack && w_in_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_out_free = !r_out_valid || i_ready;
    assign w_skid_nxt = r_skid_valid ? !w_out_free : (w_in_ack && !w_out_free);

    // r_not_full starts low so o_ready stays low through reset even when
    // sources already present valid; it rises on the first clock after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_not_full   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_be     <= '0;
            r_out_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_be    <= '0;
            r_skid_last  <= 1'b0;
        end else begin
            r_not_full   <= !w_skid_nxt;
            r_skid_valid <= w_skid_nxt;
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_skid_data;
                    r_out_be    <= r_skid_be;
                    r_out_last  <= r_skid_last;
                end else begin
                    r_out_valid <= w_in_ack;
                    if (w_in_ack) begin
                        r_out_data <= w_in_data;
                        r_out_be   <= w_in_be;
                        r_out_last <= w_in_last;
                    end
                end
            end
            if (!r_skid_valid && w_in_ack && !w_out_free) begin
                r_skid_data <= w_in_data;
                r_skid_be   <= w_in_be;
                r_skid_last <= w_in_last;
            end
        end
    end

`ifdef PZVIP_STREAM_ARBITER_CHANNEL_ID_EN
    logic [ID_WIDTH-1:0] r_out_id;
    logic [ID_WIDTH-1:0] r_skid_id;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_id  <= '0;
            r_skid_id <= '0;
        end else begin
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_id <= r_skid_id;
                end else if (w_in_ack) begin
                    r_out_id <= w_sel;
                end
            end
            if (!r_skid_valid && w_in_ack && !w_out_free) begin
                r_skid_id <= w_sel;
            end
        end
    end

    assign o_channel = r_out_id;
`endif

    assign o_valid       = r_out_valid;
    assign o_data        = r_out_data;
    assign o_byte_enable = r_out_be;
    assign o_last        = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_pzvip_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pzvip_stream_arbiter
// Purpose  : Directed and random stimulus for pzvip_stream_arbiter, checked
//            against a packet-level scoreboard and round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pzvip_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    i_valid;
    logic [N-1:0]    o_ready;
    logic [N*DW-1:0] i_data;
    logic [N*BW-1:0] i_be;
    logic [N-1:0]    i_last;
    logic            o_valid;
    logic            i_ready;
    logic [DW-1:0]   o_data;
    logic [BW-1:0]   o_be;
    logic            o_last;
`ifdef PZVIP_STREAM_ARBITER_CHANNEL_ID_EN
    logic [IW-1:0]   o_channel;
`endif

    always #5 clk = ~clk;

    pzvip_stream_arbiter #(
        .CHANNELS   (N),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .i_byte_enable (i_be),
        .i_last        (i_last),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_byte_enable (o_be),
        .o_last        (o_last)
`ifdef PZVIP_STREAM_ARBITER_CHANNEL_ID_EN
        ,
        .o_channel     (o_channel)
`endif
    );

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
        logic          last;
    } beat_t;

    // Reference model: accepted beats awaiting output, lock owner, RR pointer
    beat_t         sbq[$];
    int            lock_ch;
    int            ptr;
    bit            rdy_blocked;
    int            nchk;
    int            nfail;
    int            cyc;

    // Source state per channel
    int            len  [N];
    int            beat [N];
    bit            act  [N];
    int            hold [N];
    logic [DW-1:0] base [N];
    int            vprob;
    int            rmode;
    bit            rtog;
    logic [N-1:0]  acked;
    int            out_ch[$];
    int            out_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [BW-1:0] be_of(input logic [DW-1:0] d);
        return d[3:0] ~^ d[7:4];
    endfunction

    task automatic start_pkt(input int c, input int n, input logic [DW-1:0] b);
        len[c]  = n;
        beat[c] = 0;
        act[c]  = 1'b1;
        base[c] = b;
    endtask

    task automatic drive();
        logic [DW-1:0] d;
        for (int c = 0; c < N; c++) begin
            d                   = base[c] + DW'(beat[c]);
            i_valid[c]          = act[c] && (hold[c] == 0) && ($urandom_range(99) < vprob);
            i_data[c*DW +: DW]  = d;
            i_be[c*BW +: BW]    = be_of(d);
            i_last[c]           = (beat[c] == len[c] - 1);
        end
        case (rmode)
            0:       i_ready = 1'b1;
            1:       begin i_ready = rtog; rtog = !rtog; end
            default: i_ready = ($urandom_range(99) < 70);
        endcase
    endtask

    // Pre-edge check of outputs against the model, then model update
    task automatic sample();
        logic [N-1:0] exp_rdy;
        int           cc;
        beat_t        b;
        exp_rdy = '0;
        chk("o_valid", o_valid, sbq.size() > 0);
        if (sbq.size() > 0) begin
            chk("o_data", o_data, sbq[0].data);
            chk("o_byte_enable", o_be, sbq[0].be);
            chk("o_last", o_last, sbq[0].last);
`ifdef PZVIP_STREAM_ARBITER_CHANNEL_ID_EN
            chk("o_channel", o_channel, sbq[0].ch);
`endif
        end
        if (!rdy_blocked && sbq.size() < 2) begin
            if (lock_ch >= 0) begin
                exp_rdy[lock_ch] = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    cc = (ptr + k) % N;
                    if (i_valid[cc]) begin
                        exp_rdy[cc] = 1'b1;
                        break;
                    end
                end
            end
        end
        chk("o_ready", o_ready, exp_rdy);
        if (o_valid && i_ready && sbq.size() > 0) begin
            out_ch.push_back(sbq[0].ch);
            out_cyc.push_back(cyc);
            void'(sbq.pop_front());
        end
        acked = i_valid & o_ready;
        for (int c = 0; c < N; c++) begin
            if (acked[c]) begin
                b.ch   = c;
                b.data = i_data[c*DW +: DW];
                b.be   = i_be[c*BW +: BW];
                b.last = i_last[c];
                sbq.push_back(b);
                if (lock_ch < 0) begin
                    ptr = (c + 1) % N;
                    if (!i_last[c]) lock_ch = c;
                end else if (i_last[c]) begin
                    lock_ch = -1;
                end
            end
        end
        rdy_blocked = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < N; c++) begin
            if (acked[c]) begin
                beat[c]++;
                if (beat[c] == len[c]) act[c] = 1'b0;
            end
            if (hold[c] > 0) hold[c]--;
        end
        drive();
    endtask

    function automatic bit busy();
        bit r;
        r = (sbq.size() > 0);
        for (int c = 0; c < N; c++) r = r | act[c];
        return r;
    endfunction

    task automatic run_until_idle(input int maxc);
        int n;
        n = 0;
        while (busy() && n < maxc) begin
            tick();
            n++;
        end
        chk("drain_timeout", busy(), 0);
    endtask

    task automatic model_reset();
        sbq.delete();
        lock_ch     = -1;
        ptr         = 0;
        rdy_blocked = 1'b1;
        for (int c = 0; c < N; c++) begin
            act[c]  = 1'b0;
            hold[c] = 0;
        end
    endtask

    initial begin
        int n;
        nchk  = 0;
        nfail = 0;
        cyc   = 0;
        vprob = 100;
        rmode = 0;
        rtog  = 1'b1;
        acked = '0;
        for (int c = 0; c < N; c++) begin
            len[c]  = 1;
            beat[c] = 0;
            base[c] = '0;
        end
        model_reset();
        rst_n = 1'b0;

        // Reset state, with every channel already offering a 2-beat packet
        for (int c = 0; c < N; c++) start_pkt(c, 2, DW'((c + 1) * 256));
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_ready", o_ready, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_byte_enable", o_be, 0);
        chk("rst_o_last", o_last, 0);
`ifdef PZVIP_STREAM_ARBITER_CHANNEL_ID_EN
        chk("rst_o_channel", o_channel, 0);
`endif
        rst_n = 1'b1;
        out_ch.delete();
        out_cyc.delete();
        run_until_idle(60);
        chk("rr_beats", out_ch.size(), 8);
        for (int i = 0; i < 8; i++) if (i < out_ch.size()) chk("rr_order", out_ch[i], i / 2);
        if (out_cyc.size() == 8) chk("rr_back_to_back", out_cyc[7] - out_cyc[0], 7);

        // Single 3-beat packet on channel 1
        out_ch.delete();
        out_cyc.delete();
        start_pkt(1, 3, 32'h0000_00A0);
        drive();
        run_until_idle(30);
        chk("single_beats", out_ch.size(), 3);
        if (out_cyc.size() == 3) chk("single_rate", out_cyc[2] - out_cyc[0], 2);

        // Lock held on channel 2 while it idles mid-packet and channel 0 waits
        out_ch.delete();
        start_pkt(2, 4, 32'h0000_0200);
        drive();
        n = 0;
        while (beat[2] < 1 && n < 20) begin
            tick();
            n++;
        end
        chk("lock_first_beat", beat[2], 1);
        hold[2] = 3;
        start_pkt(0, 1, 32'h0000_0300);
        drive();
        run_until_idle(40);
        chk("lock_beats", out_ch.size(), 5);
        for (int i = 0; i < 5; i++) if (i < out_ch.size()) chk("lock_order", out_ch[i], (i < 4) ? 2 : 0);

        // Backpressure: i_ready alternates during a 6-beat packet
        out_ch.delete();
        rmode = 1;
        start_pkt(0, 6, 32'h0000_0400);
        drive();
        run_until_idle(60);
        chk("bp_beats", out_ch.size(), 6);
        rmode = 0;

        // Asynchronous reset in the middle of a 4-beat packet
        start_pkt(1, 4, 32'h0000_0500);
        drive();
        n = 0;
        while (beat[1] < 2 && n < 20) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_o_valid", o_valid, 0);
        chk("arst_o_ready", o_ready, 0);
        model_reset();
        start_pkt(3, 1, 32'h0000_0600);
        drive();
        #1;
        chk("arst_ready_in_reset", o_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ch.delete();
        run_until_idle(30);
        chk("arst_beats", out_ch.size(), 1);
        if (out_ch.size() > 0) chk("arst_first_ch", out_ch[0], 3);

        // Random traffic with random valid gaps and backpressure
        rmode = 2;
        vprob = 70;
        for (int it = 0; it < 400; it++) begin
            for (int c = 0; c < N; c++) begin
                if (!act[c] && $urandom_range(3) == 0) start_pkt(c, int'($urandom_range(1, 5)), $urandom);
            end
            drive();
            tick();
        end
        run_until_idle(400);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
